// File: rtl/tile_sequencer.sv
// tile_sequencer: two-level loop sequencer. It walks a NUM_ROWS x NUM_COLS tile with the
// column index innermost. It presents one (row, col) coordinate per valid/ready transfer
// and ends each run with a one-cycle DONE pulse.
//
// Optional feature macro: TILE_SEQ_LAST_EN adds the out_last port. When set, out_last
// flags the final coordinate of the tile.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   start      run request, sampled only while idle
//   num_rows   row count, latched on an accepted start
//   num_cols   column count, latched on an accepted start
//   busy       high while running or signalling done
//   done       one-cycle completion pulse
//   out_valid  out_row/out_col hold a valid coordinate
//   out_ready  downstream accepts the coordinate
//   out_row    current row index
//   out_col    current column index
//   out_last   final coordinate of the tile (TILE_SEQ_LAST_EN only)
module tile_sequencer #(
  parameter int ROW_BITS = 8,
  parameter int COL_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ROW_BITS-1:0] num_rows,
  input  logic [COL_BITS-1:0] num_cols,
  output logic                busy,
  output logic                done,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ROW_BITS-1:0] out_row,
  output logic [COL_BITS-1:0] out_col
`ifdef TILE_SEQ_LAST_EN
  ,
  output logic                out_last
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t              state;
  logic [ROW_BITS-1:0] rows_q;
  logic [COL_BITS-1:0] cols_q;

  logic [ROW_BITS-1:0] row_nxt;
  logic [COL_BITS-1:0] col_nxt;
  logic                row_end;
  logic                col_end;

  // Counts are nonzero whenever these are used (zero counts never enter StRun).
  always_comb begin
    row_nxt = out_row + ROW_BITS'(1);
    col_nxt = out_col + COL_BITS'(1);
    row_end = (out_row == rows_q - ROW_BITS'(1));
    col_end = (out_col == cols_q - COL_BITS'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= StIdle;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            rows_q  <= num_rows;
            cols_q  <= num_cols;
            out_row <= '0;
            out_col <= '0;
            busy    <= 1'b1;
            if (num_rows == '0 || num_cols == '0) begin
              state <= StDone;
              done  <= 1'b1;
            end else begin
              state     <= StRun;
              out_valid <= 1'b1;
            end
          end
        end
        StRun: begin
          if (out_ready) begin
            if (!col_end) begin
              out_col <= col_nxt;
            end else if (!row_end) begin
              out_col <= '0;
              out_row <= row_nxt;
            end else begin
              // Indices hold at the final coordinate; they clear on the way back to idle.
              state     <= StDone;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        StDone: begin
          state   <= StIdle;
          done    <= 1'b0;
          busy    <= 1'b0;
          out_row <= '0;
          out_col <= '0;
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef TILE_SEQ_LAST_EN
  // Predicts whether the coordinate loaded this edge is the final one, so out_last stays
  // aligned with the registered indices and holds under back-pressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_last <= 1'b0;
    end else if (state == StIdle) begin
      if (start) begin
        out_last <= (num_rows == ROW_BITS'(1)) && (num_cols == COL_BITS'(1));
      end
    end else if (state == StRun) begin
      if (out_ready) begin
        if (!col_end) begin
          out_last <= row_end && (col_nxt == cols_q - COL_BITS'(1));
        end else if (!row_end) begin
          out_last <= (row_nxt == rows_q - ROW_BITS'(1)) && (cols_q == COL_BITS'(1));
        end else begin
          out_last <= 1'b0;
        end
      end
    end else begin
      out_last <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// Self-checking bench for tile_sequencer. Two instances share stimulus:
//   dut0 uses 8-bit counts.
//   dut1 uses 2-bit counts and sees only the low two bits of the counts.
// A transfer-count model predicts every output on every cycle. Directed scenarios are
// also pinned with literal coordinate lists.
module tb_tile_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] nr = 8'd0;
  logic [7:0] nc = 8'd0;

  logic       busy0, done0, valid0;
  logic [7:0] row0, col0;
  logic       busy1, done1, valid1;
  logic [1:0] row1, col1;
`ifdef TILE_SEQ_LAST_EN
  logic       last0, last1;
`endif

  tile_sequencer #(.ROW_BITS(8), .COL_BITS(8)) dut0 (
    .clk(clk), .reset(reset), .start(start), .num_rows(nr), .num_cols(nc),
    .busy(busy0), .done(done0), .out_valid(valid0), .out_ready(out_ready),
    .out_row(row0), .out_col(col0)
`ifdef TILE_SEQ_LAST_EN
    , .out_last(last0)
`endif
  );

  tile_sequencer #(.ROW_BITS(2), .COL_BITS(2)) dut1 (
    .clk(clk), .reset(reset), .start(start), .num_rows(nr[1:0]), .num_cols(nc[1:0]),
    .busy(busy1), .done(done1), .out_valid(valid1), .out_ready(out_ready),
    .out_row(row1), .out_col(col1)
`ifdef TILE_SEQ_LAST_EN
    , .out_last(last1)
`endif
  );

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  // Model per instance:
  //   ph: 0 idle, 1 emitting, 2 done.
  //   k:  number of transfers completed.
  //   mr, mc: the latched row and column counts.
  int ph[2], k[2], mr[2], mc[2];

  // Observation logs. Coordinates are encoded as row*256 + col.
  int xlog0[$], xlog1[$], vlog0[$], lastlog1[$], exp_q[$];
  int last_xfer_cyc = -1, done_cyc = -1, done_cnt0 = 0;
  int wait_n;
  int pat[6] = '{1, 0, 1, 1, 0, 1};

  task automatic cmp(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      int r, c;
      r = (i == 0) ? int'(nr) : int'(nr[1:0]);
      c = (i == 0) ? int'(nc) : int'(nc[1:0]);
      if (reset) begin
        ph[i] = 0;
        k[i]  = 0;
      end else if (ph[i] == 0) begin
        if (start) begin
          mr[i] = r;
          mc[i] = c;
          k[i]  = 0;
          ph[i] = (r == 0 || c == 0) ? 2 : 1;
        end
      end else if (ph[i] == 1) begin
        if (out_ready) begin
          k[i]++;
          if (k[i] == mr[i] * mc[i]) ph[i] = 2;
        end
      end else begin
        ph[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        int a_v, a_b, a_d, a_r, a_c;
        a_v = (i == 0) ? int'(valid0) : int'(valid1);
        a_b = (i == 0) ? int'(busy0) : int'(busy1);
        a_d = (i == 0) ? int'(done0) : int'(done1);
        a_r = (i == 0) ? int'(row0) : int'(row1);
        a_c = (i == 0) ? int'(col0) : int'(col1);
        cmp($sformatf("valid%0d", i), a_v, int'(ph[i] == 1));
        cmp($sformatf("busy%0d", i), a_b, int'(ph[i] != 0));
        cmp($sformatf("done%0d", i), a_d, int'(ph[i] == 2));
        if (ph[i] == 1) begin
          cmp($sformatf("row%0d", i), a_r, k[i] / mc[i]);
          cmp($sformatf("col%0d", i), a_c, k[i] % mc[i]);
        end else if (ph[i] == 0) begin
          cmp($sformatf("row%0d_idle", i), a_r, 0);
          cmp($sformatf("col%0d_idle", i), a_c, 0);
        end
`ifdef TILE_SEQ_LAST_EN
        cmp($sformatf("last%0d", i), (i == 0) ? int'(last0) : int'(last1),
            int'(ph[i] == 1 && k[i] == mr[i] * mc[i] - 1));
`endif
      end
    end
    if (valid0) vlog0.push_back(int'(row0) * 256 + int'(col0));
    if (valid0 && out_ready) begin
      xlog0.push_back(int'(row0) * 256 + int'(col0));
      last_xfer_cyc = cyc;
    end
    if (valid1 && out_ready) xlog1.push_back(int'(row1) * 256 + int'(col1));
`ifdef TILE_SEQ_LAST_EN
    if (valid1 && out_ready && last1) lastlog1.push_back(int'(row1) * 256 + int'(col1));
`endif
    if (done0 === 1'b1) begin
      done_cyc = cyc;
      done_cnt0++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    xlog0.delete();
    xlog1.delete();
    vlog0.delete();
    lastlog1.delete();
  endtask

  task automatic do_start(input int r, input int c, output int st);
    start = 1'b1;
    nr    = 8'(r);
    nc    = 8'(c);
    st    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    wait_n = 0;
    while (wait_n < 300) begin
      tick();
      wait_n++;
      if (!busy0 && !busy1) break;
    end
    cmp({name, "_timeout"}, int'(wait_n < 300), 1);
  endtask

  // sel: 0 transfers of dut0, 1 transfers of dut1, 2 valid cycles of dut0, 3 dut1 last flags.
  task automatic check_log(input string name, input int sel);
    int a[$];
    if (sel == 0) a = xlog0;
    else if (sel == 1) a = xlog1;
    else if (sel == 2) a = vlog0;
    else a = lastlog1;
    cmp({name, "_count"}, a.size(), exp_q.size());
    for (int j = 0; j < a.size() && j < exp_q.size(); j++) cmp(name, a[j], exp_q[j]);
  endtask

  initial begin
    int st, dc;
    tick();
    tick();
    cmp_en = 1'b1;
    reset  = 1'b0;
    cmp("rst_busy", int'(busy0), 0);
    cmp("rst_valid", int'(valid0), 0);
    cmp("rst_done", int'(done0), 0);
    cmp("rst_row", int'(row0), 0);

    // Basic 2x3 run.
    clear_logs();
    out_ready = 1'b1;
    do_start(2, 3, st);
    cmp("basic_first_valid", int'(valid0), 1);
    wait_idle("basic");
    exp_q = '{0, 1, 2, 256, 257, 258};
    check_log("basic_xfer0", 0);
    check_log("basic_valid0", 2);
    check_log("basic_xfer1", 1);
    cmp("basic_done_lat", done_cyc, last_xfer_cyc + 1);

    // Back-pressure on (0,1) and (0,3).
    clear_logs();
    do_start(1, 4, st);
    for (int j = 0; j < 6; j++) begin
      out_ready = pat[j][0];
      tick();
    end
    out_ready = 1'b1;
    wait_idle("bp");
    exp_q = '{0, 1, 1, 2, 3, 3};
    check_log("bp_hold", 2);
    exp_q = '{0, 1, 2, 3};
    check_log("bp_xfer", 0);
    cmp("bp_done_lat", done_cyc, last_xfer_cyc + 1);

    // Zero count.
    clear_logs();
    dc = done_cnt0;
    do_start(0, 5, st);
    wait_idle("zero");
    cmp("zero_no_valid", vlog0.size(), 0);
    cmp("zero_done_lat", done_cyc, st + 1);
    cmp("zero_idle_lat", wait_n, 1);
    cmp("zero_done_cnt", done_cnt0 - dc, 1);

    // START and count changes mid-run are ignored.
    clear_logs();
    do_start(3, 3, st);
    tick();
    tick();
    start = 1'b1;
    nr    = 8'd1;
    nc    = 8'd2;
    tick();
    start = 1'b0;
    nc    = 8'd1;
    wait_idle("ign");
    exp_q = '{0, 1, 2, 256, 257, 258, 512, 513, 514};
    check_log("ign_xfer0", 0);
    check_log("ign_xfer1", 1);

    // Reset after the third transfer of a 4x4 tile.
    dc = done_cnt0;
    do_start(4, 4, st);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("rstrun_valid", int'(valid0), 0);
    cmp("rstrun_busy", int'(busy0), 0);
    cmp("rstrun_row", int'(row0), 0);
    cmp("rstrun_col", int'(col0), 0);
    cmp("rstrun_done", int'(done0), 0);
    tick();
    cmp("rstrun_no_done", done_cnt0 - dc, 0);
    clear_logs();
    do_start(1, 1, st);
    wait_idle("rstrun2");
    exp_q = '{0};
    check_log("rstrun2_xfer", 0);
    cmp("rstrun2_done", done_cnt0 - dc, 1);

    // Maximum size on the 2-bit instance, then restart right after DONE.
    clear_logs();
    do_start(3, 3, st);
    wait_n = 0;
    while (wait_n < 100 && done1 !== 1'b1) begin
      tick();
      wait_n++;
    end
    cmp("max_done_timeout", int'(wait_n < 100), 1);
    exp_q = '{0, 1, 2, 256, 257, 258, 512, 513, 514};
    check_log("max_xfer1", 1);
`ifdef TILE_SEQ_LAST_EN
    exp_q = '{514};
    check_log("max_last1", 3);
`endif
    tick();
    cmp("max_idle_busy", int'(busy1), 0);
    do_start(1, 1, st);
    cmp("max_restart_valid", int'(valid1), 1);
    wait_idle("max_restart");

    // Randomized traffic, checked by the model.
    for (int j = 0; j < 600; j++) begin
      reset     = ($urandom_range(0, 99) == 0);
      start     = ($urandom_range(0, 3) == 0);
      nr        = 8'($urandom_range(0, 5));
      nc        = 8'($urandom_range(0, 5));
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    wait_idle("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
